// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) arbiter in front of a single-ported
// word memory with variable-latency handshake and a 15-cycle timeout.
// Optional feature: define MEM_ARBITER_RR_EN to alternate the winner on
// simultaneous requests; otherwise the data port has fixed priority.
module mem_arbiter (
  input  logic        CLOCK,
  input  logic        RST_N,
  input  logic        if_req,
  input  logic [8:0]  if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [8:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [8:0]  m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        owner,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state, w_state;
  logic        r_m_req, w_m_req;
  logic        r_m_we, w_m_we;
  logic [8:0]  r_m_addr, w_m_addr;
  logic [31:0] r_m_wdata, w_m_wdata;
  logic        r_if_ack, w_if_ack;
  logic        r_d_ack, w_d_ack;
  logic [31:0] r_if_rdata, w_if_rdata;
  logic [31:0] r_d_rdata, w_d_rdata;
  logic        r_owner, w_owner;
  logic        r_busy, w_busy;
  logic        r_err, w_err;
  logic [3:0]  r_cnt, w_cnt;
  logic        r_last, w_last;
  logic        w_pick_d;

  // Winner selection: 1 = data port, 0 = fetch port. A lone requester always wins.
  always_comb begin
`ifdef MEM_ARBITER_RR_EN
    // On a tie the port that lost the previous grant goes next.
    w_pick_d = d_req & (~if_req | ~r_last);
`else
    w_pick_d = d_req;
`endif
  end

  // Next-state and next-output computation for the IDLE/WAIT/DONE sequencer.
  always_comb begin
    w_state    = r_state;
    w_m_req    = r_m_req;
    w_m_we     = r_m_we;
    w_m_addr   = r_m_addr;
    w_m_wdata  = r_m_wdata;
    w_if_ack   = 1'b0;
    w_d_ack    = 1'b0;
    w_if_rdata = r_if_rdata;
    w_d_rdata  = r_d_rdata;
    w_owner    = r_owner;
    w_busy     = r_busy;
    w_err      = r_err;
    w_cnt      = r_cnt;
    w_last     = r_last;
    case (r_state)
      ST_IDLE: begin
        if (if_req | d_req) begin
          w_state   = ST_WAIT;
          w_m_req   = 1'b1;
          w_m_we    = w_pick_d ? d_we : 1'b0;
          w_m_addr  = w_pick_d ? d_addr : if_addr;
          w_m_wdata = w_pick_d ? d_wdata : 32'd0;
          w_owner   = w_pick_d;
          w_last    = w_pick_d;
          w_busy    = 1'b1;
          w_cnt     = 4'd0;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (m_ack) begin
          // Normal completion wins even on the edge the counter would hit 15.
          w_state = ST_DONE;
          w_m_req = 1'b0;
          if (!r_m_we) begin
            if (r_owner) begin
              w_d_rdata = m_rdata;
            end else begin
              w_if_rdata = m_rdata;
            end
          end else begin
            w_d_rdata = r_d_rdata;
          end
          w_d_ack  = r_owner;
          w_if_ack = ~r_owner;
        end else if (r_cnt == 4'd14) begin
          // Counter reaches 15 with no response: abort with poison data.
          w_state = ST_DONE;
          w_m_req = 1'b0;
          w_cnt   = 4'd15;
          w_err   = 1'b1;
          if (r_owner) begin
            w_d_rdata = 32'hFFFF_FFFF;
          end else begin
            w_if_rdata = 32'hFFFF_FFFF;
          end
          w_d_ack  = r_owner;
          w_if_ack = ~r_owner;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = ST_IDLE;
        w_m_req = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= 9'd0;
      r_m_wdata  <= 32'd0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_if_rdata <= 32'd0;
      r_d_rdata  <= 32'd0;
      r_owner    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= 4'd0;
      r_last     <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_m_req    <= w_m_req;
      r_m_we     <= w_m_we;
      r_m_addr   <= w_m_addr;
      r_m_wdata  <= w_m_wdata;
      r_if_ack   <= w_if_ack;
      r_d_ack    <= w_d_ack;
      r_if_rdata <= w_if_rdata;
      r_d_rdata  <= w_d_rdata;
      r_owner    <= w_owner;
      r_busy     <= w_busy;
      r_err      <= w_err;
      r_cnt      <= w_cnt;
      r_last     <= w_last;
    end
  end

  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign if_ack   = r_if_ack;
  assign d_ack    = r_d_ack;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;
  assign owner    = r_owner;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-low.
REQ-002 CLOCK  input  1  rising-edge clock for all state.
REQ-003 RST_N  input  1  synchronous active-low reset, sampled on rising CLOCK.
REQ-004 if_req  input  1  fetch port request, read-only, held until if_ack.
REQ-005 if_addr  input  9  fetch word address, 0..511.
REQ-006 if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 if_rdata  output  32  fetch read data, valid while if_ack=1 and held afterwards.
REQ-008 d_req  input  1  data port request, held until d_ack.
REQ-009 d_we  input  1  data port write enable (1=sw, 0=lw).
REQ-010 d_addr  input  9  data word address.
REQ-011 d_wdata  input  32  data port write data.
REQ-012 d_ack  output  1  one-cycle data completion pulse.
REQ-013 d_rdata  output  32  data port read data; unchanged by writes.
REQ-014 m_req  output  1  memory request, registered.
REQ-015 m_we, m_addr[8:0], m_wdata[31:0]  outputs  memory command fields, registered.
REQ-016 m_ack  input  1  memory completion, any latency of 1 cycle or more.
REQ-017 m_rdata  input  32  memory read data, valid with m_ack.
REQ-018 owner  output  1  port being served (0=fetch, 1=data); valid only while busy=1.
REQ-019 busy  output  1  high in WAIT and DONE.
REQ-020 err  output  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-022 IDLE: if any request is sampled high, the FSM SHALL latch the winner's address, we and wdata into m_addr/m_we/m_wdata, set m_req=1 and owner=winner, and enter WAIT on the same edge.
REQ-023 WAIT: m_req and all command fields SHALL stay stable until m_ack is sampled high.
REQ-024 On that m_ack edge the FSM SHALL clear m_req, capture m_rdata into the winner's rdata register (reads only), set the winner's ack=1 and enter DONE.
REQ-025 DONE SHALL last exactly one cycle with ack high, then return to IDLE with ack cleared.
REQ-026 Requests SHALL be ignored in WAIT and DONE.
REQ-027 A requester SHALL drop req in the cycle after it sees ack. The arbiter first samples that port again two edges after the ack edge.
REQ-028 Minimum latency: req sampled at edge N, m_req high from N, m_ack at N+1, ack high in the cycle after edge N+1, for a 2-cycle round trip.
REQ-029 Timeout: a 4-bit counter SHALL clear on WAIT entry and increment each WAIT cycle without m_ack.
REQ-030 When the counter reaches 15 with m_ack still low, the FSM SHALL clear m_req, load the winner's rdata with 32'hFFFFFFFF (also for writes), set err=1, pulse ack and enter DONE.
REQ-031 If m_ack arrives on the same edge the counter reaches 15, it SHALL count as normal completion with no error.
REQ-032 m_ack sampled outside WAIT SHALL be ignored.
REQ-033 Fixed priority (macro absent): d_req SHALL win over if_req on a simultaneous request.
REQ-034 A 1-bit last-winner register SHALL update on every grant in both configurations.

Reset
REQ-035 When RST_N=0 at an edge, including mid-transaction, the block SHALL enter IDLE with m_req=0, m_we=0, m_addr=0, m_wdata=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, owner=0, busy=0, err=0, timeout counter=0 and last-winner=1.
REQ-036 A transaction aborted by reset SHALL produce no ack, and an m_ack received afterwards SHALL be ignored.

Configuration
REQ-037 The block SHALL use one macro, MEM_ARBITER_RR_EN.
REQ-038 With MEM_ARBITER_RR_EN defined, on a simultaneous request the port that did not win the previous grant SHALL win. A single requester always wins.
REQ-039 Without MEM_ARBITER_RR_EN, fixed data-over-fetch priority per REQ-033 SHALL apply. The last-winner register still exists but does not affect arbitration.

Verification
REQ-040 Fetch read: if_req=1, if_addr=5, memory m_ack 1 cycle after m_req with m_rdata=32'h0000_1234 -> m_addr=5, m_we=0, if_ack pulses 1 cycle, if_rdata=32'h0000_1234, d_ack stays 0.
REQ-041 Data write: d_req=1, d_we=1, d_addr=9, d_wdata=32'hCAFE_0001, m_ack after 3 cycles -> m_we=1 and fields stable for 3 cycles, d_ack pulse, d_rdata unchanged.
REQ-042 Tie, fixed priority: if_req and d_req asserted together and held -> data served first, fetch second. With MEM_ARBITER_RR_EN and both held for 4 transactions -> owners in order 0,1,0,1.
REQ-043 Timeout: d_req read and m_ack never asserted -> m_req drops after 15 WAIT cycles, d_ack=1, d_rdata=32'hFFFFFFFF, err=1 until reset.
REQ-044 Reset mid-WAIT: RST_N=0 for 1 cycle during WAIT, then m_ack=1 -> no ack pulse, all outputs at reset values, busy=0.
REQ-045 Boundary address: d_addr=511 read with m_rdata=32'h8000_0000 -> m_addr=511, d_rdata=32'h8000_0000.
